// File: rtl/kbd_term.sv
// kbd_term: PS/2 scan code set 2 decoder writing ASCII + attribute into an 80x25 CGA text buffer.
// Optional KBD_TERM_CLEAR_EN: blank the whole screen (0x20/ATTR pairs) after every reset.
module kbd_term #(
   parameter int         COLS = 80,
   parameter int         ROWS = 25,
   parameter logic [7:0] ATTR = 8'h07
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  ps2_data,
   input  logic        ps2_hit,
   output logic [12:0] mem_address,
   output logic [7:0]  mem_data,
   output logic        mem_we,
   output logic [10:0] cursor,
   output logic        busy
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   typedef enum logic [1:0] {
`ifdef KBD_TERM_CLEAR_EN
      S_CLEAR,
`endif
      S_IDLE,
      S_WR_CHAR,
      S_WR_ATTR
   } state_t;

   state_t          r_state, w_state_n;
   logic [CW-1:0]   r_col, w_col_n;
   logic [RW-1:0]   r_row, w_row_n, w_row_inc;
   logic [10:0]     r_cursor;
   logic            r_brk, w_brk_n, r_ext, w_ext_n;
   logic            r_shift, w_shift_n, r_caps, w_caps_n;
   logic            r_pend_v, w_pend_v_n;
   logic [7:0]      r_pend_d, w_pend_d_n;
   logic            r_is_bs, w_is_bs_n;
   logic            r_we, w_we_n;
   logic [12:0]     r_addr, w_addr_n;
   logic [7:0]      r_data, w_data_n;
   logic            w_byte_v;
   logic [7:0]      w_byte;
   logic [8:0]      w_xl;
`ifdef KBD_TERM_CLEAR_EN
   localparam logic [12:0] LAST_ADDR = 13'(2 * COLS * ROWS - 1);
   logic [12:0]     r_clr_cnt, w_clr_cnt_n;
`endif

   function automatic logic [10:0] lin(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return 11'(r) * 11'(COLS) + 11'(c);
   endfunction

   // Returns {valid, ascii}; letters are upper case when exactly one of shift/caps is active.
   function automatic logic [8:0] xlate(input logic [7:0] code, input logic shift, input logic caps);
      logic [7:0] ch;
      logic       v;
      v  = 1'b1;
      ch = 8'h00;
      case (code)
         8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
         8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
         8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
         8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
         8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
         8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
         8'h35: ch = "y";  8'h1A: ch = "z";
         8'h16: ch = shift ? "!" : "1";
         8'h1E: ch = shift ? "@" : "2";
         8'h26: ch = shift ? "#" : "3";
         8'h25: ch = shift ? "$" : "4";
         8'h2E: ch = shift ? "%" : "5";
         8'h36: ch = shift ? "^" : "6";
         8'h3D: ch = shift ? "&" : "7";
         8'h3E: ch = shift ? "*" : "8";
         8'h46: ch = shift ? "(" : "9";
         8'h45: ch = shift ? ")" : "0";
         8'h29: ch = " ";
         default: v = 1'b0;
      endcase
      if (ch >= "a" && ch <= "z" && (shift ^ caps)) ch = ch - 8'h20;
      return {v, ch};
   endfunction

   assign w_byte_v  = r_pend_v | ps2_hit;
   assign w_byte    = r_pend_v ? r_pend_d : ps2_data;
   assign w_xl      = xlate(w_byte, r_shift, r_caps);
   assign w_row_inc = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_n  = r_state;
      w_col_n    = r_col;
      w_row_n    = r_row;
      w_brk_n    = r_brk;
      w_ext_n    = r_ext;
      w_shift_n  = r_shift;
      w_caps_n   = r_caps;
      w_is_bs_n  = r_is_bs;
      w_we_n     = 1'b0;
      w_addr_n   = r_addr;
      w_data_n   = r_data;
      w_pend_v_n = r_pend_v;
      w_pend_d_n = r_pend_d;
`ifdef KBD_TERM_CLEAR_EN
      w_clr_cnt_n = r_clr_cnt;
`endif

      // The pending byte is consumed in IDLE; a simultaneous hit takes over the freed slot.
      if (r_state == S_IDLE) begin
         w_pend_v_n = r_pend_v & ps2_hit;
         if (r_pend_v && ps2_hit) w_pend_d_n = ps2_data;
      end else if (ps2_hit && !r_pend_v) begin
         w_pend_v_n = 1'b1;
         w_pend_d_n = ps2_data;
      end

      case (r_state)
`ifdef KBD_TERM_CLEAR_EN
         S_CLEAR: begin
            w_we_n      = 1'b1;
            w_addr_n    = r_clr_cnt;
            w_data_n    = r_clr_cnt[0] ? ATTR : 8'h20;
            w_clr_cnt_n = r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_ADDR) w_state_n = S_IDLE;
         end
`endif
         S_IDLE: begin
            if (w_byte_v) begin
               if (w_byte == 8'hF0) begin
                  w_brk_n = 1'b1;
               end else if (w_byte == 8'hE0) begin
                  w_ext_n = 1'b1;
               end else begin
                  w_brk_n = 1'b0;
                  w_ext_n = 1'b0;
                  if (!r_ext) begin
                     if (r_brk) begin
                        if (w_byte == 8'h12 || w_byte == 8'h59) w_shift_n = 1'b0;
                     end else if (w_byte == 8'h12 || w_byte == 8'h59) begin
                        w_shift_n = 1'b1;
                     end else if (w_byte == 8'h58) begin
                        w_caps_n = ~r_caps;
                     end else if (w_byte == 8'h5A) begin
                        w_col_n = '0;
                        w_row_n = w_row_inc;
                     end else if (w_byte == 8'h66) begin
                        if (r_cursor != 11'd0) begin
                           if (r_col == '0) begin
                              w_col_n = CW'(COLS - 1);
                              w_row_n = r_row - 1'b1;
                           end else begin
                              w_col_n = r_col - 1'b1;
                           end
                           w_is_bs_n = 1'b1;
                           w_state_n = S_WR_CHAR;
                           w_we_n    = 1'b1;
                           w_addr_n  = {1'b0, lin(w_row_n, w_col_n), 1'b0};
                           w_data_n  = 8'h20;
                        end
                     end else if (w_xl[8]) begin
                        w_is_bs_n = 1'b0;
                        w_state_n = S_WR_CHAR;
                        w_we_n    = 1'b1;
                        w_addr_n  = {1'b0, r_cursor, 1'b0};
                        w_data_n  = w_xl[7:0];
                     end
                  end
               end
            end
         end
         S_WR_CHAR: begin
            w_state_n = S_WR_ATTR;
            w_we_n    = 1'b1;
            w_addr_n  = {r_addr[12:1], 1'b1};
            w_data_n  = ATTR;
         end
         S_WR_ATTR: begin
            w_state_n = S_IDLE;
            if (!r_is_bs) begin
               if (r_col == CW'(COLS - 1)) begin
                  w_col_n = '0;
                  w_row_n = w_row_inc;
               end else begin
                  w_col_n = r_col + 1'b1;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
`ifdef KBD_TERM_CLEAR_EN
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
`else
         r_state   <= S_IDLE;
`endif
         r_col     <= '0;
         r_row     <= '0;
         r_cursor  <= '0;
         r_brk     <= 1'b0;
         r_ext     <= 1'b0;
         r_shift   <= 1'b0;
         r_caps    <= 1'b0;
         r_pend_v  <= 1'b0;
         r_pend_d  <= '0;
         r_is_bs   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         r_state   <= w_state_n;
`ifdef KBD_TERM_CLEAR_EN
         r_clr_cnt <= w_clr_cnt_n;
`endif
         r_col     <= w_col_n;
         r_row     <= w_row_n;
         r_cursor  <= lin(w_row_n, w_col_n);
         r_brk     <= w_brk_n;
         r_ext     <= w_ext_n;
         r_shift   <= w_shift_n;
         r_caps    <= w_caps_n;
         r_pend_v  <= w_pend_v_n;
         r_pend_d  <= w_pend_d_n;
         r_is_bs   <= w_is_bs_n;
         r_we      <= w_we_n;
         r_addr    <= w_addr_n;
         r_data    <= w_data_n;
      end
   end

   assign mem_address = r_addr;
   assign mem_data    = r_data;
   assign mem_we      = r_we;
   assign cursor      = r_cursor;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_kbd_term.sv
// Bench for kbd_term: directed scan-code sequences; expected memory writes go through a scoreboard
// queue checked by an independent monitor, cursor/reset values are checked inline.
module tb_kbd_term;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b0;
   logic [7:0]  ps2_data = 8'h00;
   logic        ps2_hit  = 1'b0;
   logic [12:0] mem_address;
   logic [7:0]  mem_data;
   logic        mem_we;
   logic [10:0] cursor;
   logic        busy;

`ifdef KBD_TERM_CLEAR_EN
   localparam logic BUSY_AT_RST = 1'b1;
`else
   localparam logic BUSY_AT_RST = 1'b0;
`endif

   typedef struct packed {
      logic [12:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_bad = 0;

   always #5 clock = ~clock;

   kbd_term dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ps2_data    (ps2_data),
      .ps2_hit     (ps2_hit),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_we      (mem_we),
      .cursor      (cursor),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT presents must match the head of the scoreboard.
   initial begin : monitor
      wr_t e;
      forever begin
         @(negedge clock);
         if (reset_n && mem_we) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_write: addr %0d data %02h, no write expected", mem_address, mem_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(mem_address), 32'(e.addr));
               check("wr_data", 32'(mem_data), 32'(e.data));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      ps2_data = b;
      ps2_hit  = 1'b1;
      @(negedge clock);
      ps2_hit  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clock);
         k++;
      end
      if (busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
      end
      @(negedge clock);
   endtask

   task automatic key(input logic [7:0] b);
      send(b);
      wait_idle(10);
   endtask

   task automatic put(input logic [7:0] b, input logic [7:0] ch, input int cur);
      exp_q.push_back({13'(2 * cur), ch});
      exp_q.push_back({13'(2 * cur + 1), 8'h07});
      key(b);
   endtask

   task automatic do_reset();
      ps2_hit = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #2;
      check("rst_we", 32'(mem_we), 0);
      check("rst_addr", 32'(mem_address), 0);
      check("rst_data", 32'(mem_data), 0);
      check("rst_cursor", 32'(cursor), 0);
      check("rst_busy", 32'(busy), 32'(BUSY_AT_RST));
      @(negedge clock);
      reset_n = 1'b1;
`ifdef KBD_TERM_CLEAR_EN
      for (int i = 0; i < 4000; i++) exp_q.push_back({13'(i), (i % 2 == 1) ? 8'h07 : 8'h20});
      wait_idle(4100);
      check("clr_drained", 32'(exp_q.size()), 0);
      check("clr_cursor", 32'(cursor), 0);
`endif
   endtask

   initial begin : stim
      do_reset();

      // Shift make, 'a' -> 'A' at 0; cursor moves only after the attribute write.
      key(8'h12);
      exp_q.push_back({13'd0, 8'h41});
      exp_q.push_back({13'd1, 8'h07});
      send(8'h1C);
      check("cursor_hold_n1", 32'(cursor), 0);
      wait_idle(10);
      check("cursor_after_A", 32'(cursor), 1);
      key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
      check("cursor_breaks", 32'(cursor), 1);
      put(8'h1C, 8'h61, 1);
      check("cursor_after_a", 32'(cursor), 2);

      // Caps Lock, Shift+Caps, digits with Shift / Caps, space.
      key(8'h58);
      put(8'h1C, "A", 2);
      key(8'hF0); key(8'h1C);
      key(8'h12);
      put(8'h1C, "a", 3);
      key(8'hF0); key(8'h12);
      put(8'h16, "1", 4);
      key(8'h59);
      put(8'h16, "!", 5);
      key(8'hF0); key(8'h59);
      key(8'h58);
      put(8'h29, " ", 6);
      put(8'h32, "b", 7);
      check("cursor_8", 32'(cursor), 8);

      // Extended codes, unmapped codes and break codes produce nothing.
      key(8'hE0); key(8'h1C);
      key(8'hE0); key(8'hF0); key(8'h1C);
      key(8'h76);
      key(8'hF0); key(8'h32);
      check("cursor_ignored", 32'(cursor), 8);

      // Enter: cursor updated the cycle after the hit, no memory cycle.
      send(8'h5A);
      check("enter_n1", 32'(cursor), 80);
      check("enter_busy", 32'(busy), 0);
      wait_idle(10);

      // Backspace from column 0 of row 1 wraps to 79 and blanks it.
      exp_q.push_back({13'd158, 8'h20});
      exp_q.push_back({13'd159, 8'h07});
      send(8'h66);
      check("bs_cursor_n1", 32'(cursor), 79);
      wait_idle(10);
      check("bs_cursor", 32'(cursor), 79);
      put(8'h21, "c", 79);
      check("cursor_80", 32'(cursor), 80);

      // Backspace at 0 is ignored; fill to the last cell and wrap to the top.
      do_reset();
      key(8'h66);
      check("bs_at_zero", 32'(cursor), 0);
      repeat (24) key(8'h5A);
      check("cursor_1920", 32'(cursor), 1920);
      for (int i = 0; i < 79; i++) put(8'h1A, "z", 1920 + i);
      check("cursor_1999", 32'(cursor), 1999);
      put(8'h1C, "a", 1999);
      check("cursor_wrap", 32'(cursor), 0);
      repeat (25) key(8'h5A);
      check("enter_row_wrap", 32'(cursor), 0);

      // Back-to-back hits: second goes to pending, third is dropped.
      do_reset();
      exp_q.push_back({13'd0, 8'h61});
      exp_q.push_back({13'd1, 8'h07});
      exp_q.push_back({13'd2, 8'h62});
      exp_q.push_back({13'd3, 8'h07});
      @(negedge clock); ps2_data = 8'h1C; ps2_hit = 1'b1;
      @(negedge clock); ps2_data = 8'h32;
      @(negedge clock); ps2_data = 8'h21;
      @(negedge clock); ps2_hit = 1'b0;
      repeat (12) @(negedge clock);
      check("pend_cursor", 32'(cursor), 2);
      check("pend_busy", 32'(busy), 0);

      // Reset in the middle of a character write.
      @(negedge clock); ps2_data = 8'h1C; ps2_hit = 1'b1;
      @(posedge clock);
      #1;
      ps2_hit = 1'b0;
      check("midwr_we_active", 32'(mem_we), 1);
      reset_n = 1'b0;
      #1;
      check("midwr_rst_we", 32'(mem_we), 0);
      check("midwr_rst_cursor", 32'(cursor), 0);
      check("midwr_rst_addr", 32'(mem_address), 0);
      check("midwr_rst_busy", 32'(busy), 32'(BUSY_AT_RST));
      repeat (2) @(negedge clock);

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
